cdb_arbiter: RTL and testbench

//  Arbitrates the single result broadcast bus (CDB) between two producers: the ALU and the load/store buffer (LSB).

---
 rtl/cdb_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single result broadcast bus (CDB) between the ALU
// and the load/store buffer. Each producer feeds a small FIFO; a round-robin
// grant over the FIFO heads drives one registered {tag,value} per cycle.
// Tag 0 means "no broadcast".
// Optional feature: define CDB_BYPASS_EN to let a live input whose FIFO is
// empty win arbitration and go straight to the bus (latency 1 instead of 2).
module cdb_arbiter #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ROB_TAG_W = 4,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_misbranch,
    input  logic [ROB_TAG_W-1:0] in_alu_tag,
    input  logic [DATA_W-1:0]    in_alu_value,
    input  logic [ROB_TAG_W-1:0] in_lsb_tag,
    input  logic [DATA_W-1:0]    in_lsb_value,
    output logic                 out_alu_stall,
    output logic                 out_lsb_stall,
    output logic [ROB_TAG_W-1:0] out_cdb_tag,
    output logic [DATA_W-1:0]    out_cdb_value,
    output logic                 out_overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    // Index 0 = ALU, index 1 = LSB throughout.
    logic [ROB_TAG_W-1:0] tag_mem [2][DEPTH];
    logic [DATA_W-1:0]    val_mem [2][DEPTH];
    logic [PTR_W-1:0]     rd_ptr  [2];
    logic [PTR_W-1:0]     wr_ptr  [2];
    logic [CNT_W-1:0]     count   [2];
    src_e                 last_grant;

    logic [ROB_TAG_W-1:0] in_tag [2];
    logic [DATA_W-1:0]    in_val [2];

    logic [1:0]           nonempty;
    logic [1:0]           cand;
    logic [1:0]           sel;
    logic [1:0]           pop;
    logic [1:0]           push_ok;
    logic [1:0]           push_drop;
    logic                 grant_valid;
    logic                 contention;
    src_e                 winner;
    logic [ROB_TAG_W-1:0] grant_tag;
    logic [DATA_W-1:0]    grant_val;

    assign in_tag[0] = in_alu_tag;
    assign in_tag[1] = in_lsb_tag;
    assign in_val[0] = in_alu_value;
    assign in_val[1] = in_lsb_value;

    assign out_alu_stall = (count[0] >= CNT_W'(DEPTH - 1));
    assign out_lsb_stall = (count[1] >= CNT_W'(DEPTH - 1));

    // Round-robin grant over the candidates, then per-FIFO pop/push decisions.
    always_comb begin
        nonempty    = '0;
        cand        = '0;
        sel         = '0;
        pop         = '0;
        push_ok     = '0;
        push_drop   = '0;
        grant_valid = 1'b0;
        contention  = 1'b0;
        winner      = SRC_ALU;
        grant_tag   = '0;
        grant_val   = '0;

        for (int unsigned p = 0; p < 2; p++) begin
            nonempty[p] = (count[p] != '0);
`ifdef CDB_BYPASS_EN
            cand[p] = nonempty[p] || (in_tag[p] != '0);
`else
            cand[p] = nonempty[p];
`endif
        end

        grant_valid = |cand;
        contention  = &cand;
        if (contention)
            winner = (last_grant == SRC_LSB) ? SRC_ALU : SRC_LSB;
        else if (cand[0])
            winner = SRC_ALU;
        else
            winner = SRC_LSB;

        sel[0] = grant_valid && (winner == SRC_ALU);
        sel[1] = grant_valid && (winner == SRC_LSB);

        for (int unsigned p = 0; p < 2; p++) begin
            // A winning input with an empty FIFO is broadcast directly and
            // must not also be enqueued.
            logic req;
            logic full;
            pop[p] = sel[p] && nonempty[p];
            req    = (in_tag[p] != '0) && !(sel[p] && !nonempty[p]);
            full   = (count[p] == CNT_W'(DEPTH));
            push_ok[p]   = req && (!full || pop[p]);
            push_drop[p] = req && full && !pop[p];
            if (sel[p]) begin
                if (nonempty[p]) begin
                    grant_tag = tag_mem[p][rd_ptr[p]];
                    grant_val = val_mem[p][rd_ptr[p]];
                end else begin
                    grant_tag = in_tag[p];
                    grant_val = in_val[p];
                end
            end
        end
    end

    // FIFO state, round-robin pointer and the registered broadcast.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned p = 0; p < 2; p++) begin
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
                count[p]  <= '0;
            end
            last_grant    <= SRC_LSB;
            out_cdb_tag   <= '0;
            out_cdb_value <= '0;
            out_overflow  <= 1'b0;
        end else if (rdy) begin
            if (in_misbranch) begin
                for (int unsigned p = 0; p < 2; p++) begin
                    rd_ptr[p] <= '0;
                    wr_ptr[p] <= '0;
                    count[p]  <= '0;
                end
                last_grant  <= SRC_LSB;
                out_cdb_tag <= '0;
            end else begin
                for (int unsigned p = 0; p < 2; p++) begin
                    if (push_ok[p]) begin
                        tag_mem[p][wr_ptr[p]] <= in_tag[p];
                        val_mem[p][wr_ptr[p]] <= in_val[p];
                        wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
                    end
                    if (pop[p])
                        rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
                    count[p] <= count[p] + CNT_W'(push_ok[p]) - CNT_W'(pop[p]);
                end
                if (contention)
                    last_grant <= winner;
                if (grant_valid) begin
                    out_cdb_tag   <= grant_tag;
                    out_cdb_value <= grant_val;
                end else begin
                    out_cdb_tag <= '0;
                end
                if (|push_drop)
                    out_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors for cdb_arbiter (default build, DEPTH=4).
module tb_cdb_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        in_misbranch;
    logic [3:0]  in_alu_tag;
    logic [31:0] in_alu_value;
    logic [3:0]  in_lsb_tag;
    logic [31:0] in_lsb_value;
    logic        out_alu_stall;
    logic        out_lsb_stall;
    logic [3:0]  out_cdb_tag;
    logic [31:0] out_cdb_value;
    logic        out_overflow;

    int checks;
    int failures;

    cdb_arbiter #(
        .DEPTH    (4),
        .ROB_TAG_W(4),
        .DATA_W   (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .in_misbranch (in_misbranch),
        .in_alu_tag   (in_alu_tag),
        .in_alu_value (in_alu_value),
        .in_lsb_tag   (in_lsb_tag),
        .in_lsb_value (in_lsb_value),
        .out_alu_stall(out_alu_stall),
        .out_lsb_stall(out_lsb_stall),
        .out_cdb_tag  (out_cdb_tag),
        .out_cdb_value(out_cdb_value),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Inputs set before tick are sampled at that edge; outputs read 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_misbranch = 1'b0;
        in_alu_tag   = '0;
        in_alu_value = '0;
        in_lsb_tag   = '0;
        in_lsb_value = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rdy = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Expected results after edges 1..8 of the saturating stream.
    logic [3:0]  exp_tag  [8] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1};
    logic [31:0] exp_val  [8] = '{32'h0, 32'hA00, 32'hB00, 32'hA01, 32'hB01, 32'hA02, 32'hB02, 32'hA03};
    logic        exp_ast  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        exp_lst  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        exp_ovf  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rdy      = 1'b1;
        clear_inputs();

        // Reset state
        do_reset();
        check("rst_tag", 32'(out_cdb_tag), 32'h0);
        check("rst_val", out_cdb_value, 32'h0);
        check("rst_ovf", 32'(out_overflow), 32'h0);
        check("rst_alu_stall", 32'(out_alu_stall), 32'h0);
        check("rst_lsb_stall", 32'(out_lsb_stall), 32'h0);

        // Single ALU result: visible two edges later for exactly one cycle
        in_alu_tag   = 4'd3;
        in_alu_value = 32'h11;
        tick();
        clear_inputs();
        check("lat_n1_tag", 32'(out_cdb_tag), 32'h0);
        tick();
        check("lat_n2_tag", 32'(out_cdb_tag), 32'h3);
        check("lat_n2_val", out_cdb_value, 32'h11);
        tick();
        check("lat_n3_tag", 32'(out_cdb_tag), 32'h0);

        // Simultaneous ALU/LSB after reset: ALU wins first tie
        do_reset();
        in_alu_tag   = 4'd5;
        in_alu_value = 32'h55;
        in_lsb_tag   = 4'd6;
        in_lsb_value = 32'h66;
        tick();
        clear_inputs();
        check("tie_e1_tag", 32'(out_cdb_tag), 32'h0);
        tick();
        check("tie_e2_tag", 32'(out_cdb_tag), 32'h5);
        check("tie_e2_val", out_cdb_value, 32'h55);
        tick();
        check("tie_e3_tag", 32'(out_cdb_tag), 32'h6);
        check("tie_e3_val", out_cdb_value, 32'h66);
        tick();
        check("tie_e4_tag", 32'(out_cdb_tag), 32'h0);

        // Both producers push every cycle: strict alternation, stalls, overflow
        do_reset();
        for (int k = 0; k < 8; k++) begin
            in_alu_tag   = 4'd1;
            in_alu_value = 32'hA00 + 32'(k);
            in_lsb_tag   = 4'd2;
            in_lsb_value = 32'hB00 + 32'(k);
            tick();
            check($sformatf("rr_tag_e%0d", k + 1), 32'(out_cdb_tag), 32'(exp_tag[k]));
            if (exp_tag[k] != 4'd0)
                check($sformatf("rr_val_e%0d", k + 1), out_cdb_value, exp_val[k]);
            check($sformatf("rr_alu_stall_e%0d", k + 1), 32'(out_alu_stall), 32'(exp_ast[k]));
            check($sformatf("rr_lsb_stall_e%0d", k + 1), 32'(out_lsb_stall), 32'(exp_lst[k]));
            check($sformatf("rr_ovf_e%0d", k + 1), 32'(out_overflow), 32'(exp_ovf[k]));
        end

        // Flush with a live ALU result: discarded, FIFOs empty, overflow kept
        clear_inputs();
        in_misbranch = 1'b1;
        in_alu_tag   = 4'd7;
        in_alu_value = 32'h77;
        tick();
        clear_inputs();
        check("fl_tag", 32'(out_cdb_tag), 32'h0);
        check("fl_alu_stall", 32'(out_alu_stall), 32'h0);
        check("fl_lsb_stall", 32'(out_lsb_stall), 32'h0);
        check("fl_ovf", 32'(out_overflow), 32'h1);
        tick();
        check("fl_e2_tag", 32'(out_cdb_tag), 32'h0);
        tick();
        check("fl_e3_tag", 32'(out_cdb_tag), 32'h0);
        check("fl_e3_ovf", 32'(out_overflow), 32'h1);

        // rdy low freezes the bus and queues; order resumes afterwards
        do_reset();
        in_alu_tag   = 4'd4;
        in_alu_value = 32'h44;
        in_lsb_tag   = 4'd9;
        in_lsb_value = 32'h99;
        tick();
        clear_inputs();
        in_alu_tag   = 4'd10;
        in_alu_value = 32'hAA;
        tick();
        check("rdy_pre_tag", 32'(out_cdb_tag), 32'h4);
        clear_inputs();
        rdy          = 1'b0;
        in_alu_tag   = 4'd11;
        in_alu_value = 32'hBB;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rdy_hold_tag_%0d", k), 32'(out_cdb_tag), 32'h4);
            check($sformatf("rdy_hold_val_%0d", k), out_cdb_value, 32'h44);
        end
        clear_inputs();
        rdy = 1'b1;
        tick();
        check("rdy_r1_tag", 32'(out_cdb_tag), 32'h9);
        check("rdy_r1_val", out_cdb_value, 32'h99);
        tick();
        check("rdy_r2_tag", 32'(out_cdb_tag), 32'hA);
        check("rdy_r2_val", out_cdb_value, 32'hAA);
        tick();
        check("rdy_r3_tag", 32'(out_cdb_tag), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
